// File: rtl/ht_mc_front.sv
// Multi-channel front end for the hash engine: round-robin command arbitration,
// in-order result routing through a tag FIFO, and table-clear sequencing.
module ht_mc_front #(
    parameter int CHANNELS  = 4,
    parameter int CMD_W     = 64,
    parameter int RES_W     = 64,
    parameter int TAG_DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*CMD_W-1:0] cmd_i,
    input  logic [CHANNELS-1:0]       cmd_valid_i,
    output logic [CHANNELS-1:0]       cmd_ready_o,
    output logic [CMD_W-1:0]          eng_cmd_o,
    output logic                      eng_valid_o,
    input  logic                      eng_ready_i,
    input  logic [RES_W-1:0]          eng_res_i,
    input  logic                      eng_res_valid_i,
    output logic                      eng_res_ready_o,
    output logic [RES_W-1:0]          res_o,
    output logic [CHANNELS-1:0]       res_valid_o,
    input  logic [CHANNELS-1:0]       res_ready_i,
    input  logic                      clear_req_i,
    output logic                      head_clear_run_o,
    output logic                      data_clear_run_o,
    input  logic                      head_clear_done_i,
    input  logic                      data_clear_done_i,
    output logic                      init_done_o,
    output logic                      orphan_err_o
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_head_done;
    logic               r_data_done;
    logic               r_clear_run;
    logic               r_eng_valid;
    logic [CMD_W-1:0]   r_eng_cmd;
    logic               r_orphan;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [IDX_W-1:0]   w_head;
    logic               w_grant_ok;
    logic               w_hi_found;
    logic               w_lo_found;
    logic [IDX_W-1:0]   w_hi_idx;
    logic [IDX_W-1:0]   w_lo_idx;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_accept;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic               w_pop;
    logic               w_enter_clear;
    logic [CHANNELS-1:0] w_cmd_ready;
    logic [CHANNELS-1:0] w_res_valid;

    assign w_fifo_full  = (r_count == CNT_W'(TAG_DEPTH));
    assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
    assign w_head       = r_tag_mem[r_rd_ptr];
    assign w_grant_ok   = (r_state == ST_RUN) && (!r_eng_valid || eng_ready_i) && !w_fifo_full;

    // Round-robin search: lowest valid index at or above rr, else lowest valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = {IDX_W{1'b0}};
        w_lo_idx   = {IDX_W{1'b0}};
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            w_lo_found = w_lo_found | cmd_valid_i[j];
            w_lo_idx   = cmd_valid_i[j] ? IDX_W'(j) : w_lo_idx;
            w_hi_found = w_hi_found | (cmd_valid_i[j] && (IDX_W'(j) >= r_rr));
            w_hi_idx   = (cmd_valid_i[j] && (IDX_W'(j) >= r_rr)) ? IDX_W'(j) : w_hi_idx;
        end
    end

    assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_accept  = w_grant_ok && w_lo_found;
    assign w_rr_nxt  = (w_gnt_idx == IDX_W'(CHANNELS - 1)) ? {IDX_W{1'b0}} : (w_gnt_idx + IDX_W'(1));
    assign w_pop     = eng_res_valid_i && !w_fifo_empty && res_ready_i[w_head];

    always_comb begin
        w_cmd_ready = {CHANNELS{1'b0}};
        w_res_valid = {CHANNELS{1'b0}};
        if (w_accept) begin
            w_cmd_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_cmd_ready = {CHANNELS{1'b0}};
        end
        if (eng_res_valid_i && !w_fifo_empty) begin
            w_res_valid[w_head] = 1'b1;
        end else begin
            w_res_valid = {CHANNELS{1'b0}};
        end
    end

    assign cmd_ready_o      = w_cmd_ready;
    assign res_valid_o      = w_res_valid;
    assign res_o            = eng_res_i;
    assign eng_res_ready_o  = w_fifo_empty ? 1'b1 : res_ready_i[w_head];
    assign eng_cmd_o        = r_eng_cmd;
    assign eng_valid_o      = r_eng_valid;
    assign head_clear_run_o = r_clear_run;
    assign data_clear_run_o = r_clear_run;
    assign init_done_o      = (r_state == ST_RUN);
    assign orphan_err_o     = r_orphan;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_START: w_state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if ((r_head_done || head_clear_done_i) && (r_data_done || data_clear_done_i)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_RUN:   w_state_nxt = clear_req_i ? ST_DRAIN : ST_RUN;
            ST_DRAIN: w_state_nxt = (w_fifo_empty && !r_eng_valid) ? ST_CLEAR : ST_DRAIN;
            default:  w_state_nxt = ST_START;
        endcase
    end

    assign w_enter_clear = (w_state_nxt == ST_CLEAR) && (r_state != ST_CLEAR);

    // Sequencer state, clear-start pulse and sticky done flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_START;
            r_clear_run <= 1'b0;
            r_head_done <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_run <= w_enter_clear;
            if (w_enter_clear) begin
                r_head_done <= 1'b0;
                r_data_done <= 1'b0;
            end else if (r_state == ST_CLEAR) begin
                r_head_done <= r_head_done | head_clear_done_i;
                r_data_done <= r_data_done | data_clear_done_i;
            end else begin
                r_head_done <= r_head_done;
                r_data_done <= r_data_done;
            end
        end
    end

    // Engine command register, arbitration pointer, tag FIFO control and orphan flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_eng_valid <= 1'b0;
            r_eng_cmd   <= {CMD_W{1'b0}};
            r_rr        <= {IDX_W{1'b0}};
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_orphan    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_eng_valid <= 1'b1;
                r_eng_cmd   <= cmd_i[int'(w_gnt_idx)*CMD_W +: CMD_W];
                r_rr        <= w_rr_nxt;
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
            end else if (eng_ready_i) begin
                r_eng_valid <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (eng_res_valid_i && w_fifo_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr] <= w_gnt_idx;
        end
    end

endmodule

// File: tb/tb_ht_mc_front.sv
// Self-checking bench for ht_mc_front: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ht_mc_front;
    localparam int CH = 4;
    localparam int CW = 64;
    localparam int RW = 64;
    localparam int TD = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*CW-1:0] cmd_i;
    logic [CH-1:0]    cmd_valid_i;
    logic [CH-1:0]    cmd_ready_o;
    logic [CW-1:0]    eng_cmd_o;
    logic             eng_valid_o;
    logic             eng_ready_i;
    logic [RW-1:0]    eng_res_i;
    logic             eng_res_valid_i;
    logic             eng_res_ready_o;
    logic [RW-1:0]    res_o;
    logic [CH-1:0]    res_valid_o;
    logic [CH-1:0]    res_ready_i;
    logic             clear_req_i;
    logic             head_clear_run_o;
    logic             data_clear_run_o;
    logic             head_clear_done_i;
    logic             data_clear_done_i;
    logic             init_done_o;
    logic             orphan_err_o;

    int total = 0;
    int bad   = 0;

    ht_mc_front #(.CHANNELS(CH), .CMD_W(CW), .RES_W(RW), .TAG_DEPTH(TD)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .eng_cmd_o(eng_cmd_o), .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i),
        .eng_res_i(eng_res_i), .eng_res_valid_i(eng_res_valid_i), .eng_res_ready_o(eng_res_ready_o),
        .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .clear_req_i(clear_req_i),
        .head_clear_run_o(head_clear_run_o), .data_clear_run_o(data_clear_run_o),
        .head_clear_done_i(head_clear_done_i), .data_clear_done_i(data_clear_done_i),
        .init_done_o(init_done_o), .orphan_err_o(orphan_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] chan_word(input int n);
        return {32'hC0DE_0000, 32'(n)};
    endfunction

    function automatic logic [CH-1:0] onehot(input int n);
        logic [CH-1:0] v;
        v = {CH{1'b0}};
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_i = {CH*CW{1'b0}};
        cmd_valid_i = {CH{1'b0}};
        eng_ready_i = 1'b0;
        eng_res_i = {RW{1'b0}};
        eng_res_valid_i = 1'b0;
        res_ready_i = {CH{1'b0}};
        clear_req_i = 1'b0;
        head_clear_done_i = 1'b0;
        data_clear_done_i = 1'b0;
    endtask

    task automatic bring_up();
        bit ok;
        ok = 1'b0;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            head_clear_done_i = (c == 2);
            data_clear_done_i = (c == 2);
            @(negedge clk);
            ok = init_done_o;
            next_cycle();
        end
        head_clear_done_i = 1'b0;
        data_clear_done_i = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bring_up init_done timeout got=%0b want=1", ok); end
    endtask

    task automatic send_cmd(input int ch);
        cmd_valid_i = onehot(ch);
        cmd_i[ch*CW +: CW] = chan_word(ch);
        @(negedge clk);
        total++;
        if (cmd_ready_o !== onehot(ch)) begin bad++; $display("FAIL send_cmd ch%0d ready got=%b want=%b", ch, cmd_ready_o, onehot(ch)); end
        next_cycle();
        cmd_valid_i = {CH{1'b0}};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cmd_valid_i = {CH{1'b1}};
        eng_res_valid_i = 1'b1;
        #1;
        total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL reset cmd_ready got=%b want=0000", cmd_ready_o); end
        total++; if (eng_valid_o !== 1'b0) begin bad++; $display("FAIL reset eng_valid got=%b want=0", eng_valid_o); end
        total++; if (eng_cmd_o !== 64'h0) begin bad++; $display("FAIL reset eng_cmd got=%h want=0", eng_cmd_o); end
        total++; if (res_valid_o !== 4'b0000) begin bad++; $display("FAIL reset res_valid got=%b want=0000", res_valid_o); end
        total++; if ({head_clear_run_o, data_clear_run_o} !== 2'b00) begin bad++; $display("FAIL reset clear_run got=%b want=00", {head_clear_run_o, data_clear_run_o}); end
        total++; if (init_done_o !== 1'b0) begin bad++; $display("FAIL reset init_done got=%b want=0", init_done_o); end
        total++; if (orphan_err_o !== 1'b0) begin bad++; $display("FAIL reset orphan got=%b want=0", orphan_err_o); end
        idle_inputs();
    endtask

    task automatic test_init();
        logic exp_run;
        logic exp_init;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            data_clear_done_i = (c == 3);
            head_clear_done_i = (c == 9);
            exp_run  = (c == 1);
            exp_init = (c >= 10);
            @(negedge clk);
            total++; if (head_clear_run_o !== exp_run) begin bad++; $display("FAIL init head_clear_run cyc%0d got=%b want=%b", c, head_clear_run_o, exp_run); end
            total++; if (data_clear_run_o !== exp_run) begin bad++; $display("FAIL init data_clear_run cyc%0d got=%b want=%b", c, data_clear_run_o, exp_run); end
            total++; if (init_done_o !== exp_init) begin bad++; $display("FAIL init init_done cyc%0d got=%b want=%b", c, init_done_o, exp_init); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_rr();
        bring_up();
        for (int n = 0; n < CH; n++) cmd_i[n*CW +: CW] = chan_word(n);
        cmd_valid_i = {CH{1'b1}};
        eng_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                total++; if (eng_cmd_o !== chan_word((k - 1) % CH)) begin bad++; $display("FAIL rr eng_cmd step%0d got=%h want=%h", k, eng_cmd_o, chan_word((k - 1) % CH)); end
                total++; if (eng_valid_o !== 1'b1) begin bad++; $display("FAIL rr eng_valid step%0d got=%b want=1", k, eng_valid_o); end
            end
            if (k < 5) begin
                total++; if (cmd_ready_o !== onehot(k % CH)) begin bad++; $display("FAIL rr cmd_ready step%0d got=%b want=%b", k, cmd_ready_o, onehot(k % CH)); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int acc;
        bring_up();
        cmd_valid_i = {CH{1'b1}};
        eng_ready_i = 1'b1;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (cmd_ready_o !== 4'b0000) acc++;
            next_cycle();
        end
        total++; if (acc !== TD) begin bad++; $display("FAIL full accepted got=%0d want=%0d", acc, TD); end
        @(negedge clk);
        total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL full cmd_ready got=%b want=0000", cmd_ready_o); end
        next_cycle();
        eng_res_valid_i = 1'b1;
        res_ready_i = {CH{1'b1}};
        eng_res_i = {$urandom, $urandom};
        @(negedge clk);
        total++; if (res_valid_o !== 4'b0001) begin bad++; $display("FAIL full res_valid got=%b want=0001", res_valid_o); end
        total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL full ready during pop got=%b want=0000", cmd_ready_o); end
        next_cycle();
        eng_res_valid_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cmd_ready_o !== 4'b0000) acc++;
            next_cycle();
        end
        total++; if (acc !== 1) begin bad++; $display("FAIL full refill accepted got=%0d want=1", acc); end
        idle_inputs();
    endtask

    task automatic test_inorder();
        logic [RW-1:0] r;
        bring_up();
        eng_ready_i = 1'b1;
        send_cmd(2);
        send_cmd(0);
        send_cmd(3);
        res_ready_i = {CH{1'b1}};
        eng_res_valid_i = 1'b1;
        r = {$urandom, $urandom};
        eng_res_i = r;
        @(negedge clk);
        total++; if (res_valid_o !== 4'b0100) begin bad++; $display("FAIL inorder first res_valid got=%b want=0100", res_valid_o); end
        total++; if (res_o !== r) begin bad++; $display("FAIL inorder res_o got=%h want=%h", res_o, r); end
        next_cycle();
        res_ready_i = 4'b1110;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (res_valid_o !== 4'b0001) begin bad++; $display("FAIL inorder stall res_valid got=%b want=0001", res_valid_o); end
            total++; if (eng_res_ready_o !== 1'b0) begin bad++; $display("FAIL inorder stall eng_res_ready got=%b want=0", eng_res_ready_o); end
            next_cycle();
        end
        res_ready_i = {CH{1'b1}};
        @(negedge clk);
        total++; if (eng_res_ready_o !== 1'b1) begin bad++; $display("FAIL inorder release eng_res_ready got=%b want=1", eng_res_ready_o); end
        next_cycle();
        @(negedge clk);
        total++; if (res_valid_o !== 4'b1000) begin bad++; $display("FAIL inorder third res_valid got=%b want=1000", res_valid_o); end
        next_cycle();
        eng_res_valid_i = 1'b0;
        @(negedge clk);
        total++; if (res_valid_o !== 4'b0000) begin bad++; $display("FAIL inorder idle res_valid got=%b want=0000", res_valid_o); end
        total++; if (orphan_err_o !== 1'b0) begin bad++; $display("FAIL inorder orphan got=%b want=0", orphan_err_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_drain();
        logic exp_run;
        bring_up();
        eng_ready_i = 1'b1;
        send_cmd(1);
        send_cmd(2);
        clear_req_i = 1'b1;
        next_cycle();
        clear_req_i = 1'b0;
        cmd_valid_i = {CH{1'b1}};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL drain cmd_ready got=%b want=0000", cmd_ready_o); end
            total++; if (init_done_o !== 1'b0) begin bad++; $display("FAIL drain init_done got=%b want=0", init_done_o); end
            total++; if (head_clear_run_o !== 1'b0) begin bad++; $display("FAIL drain early clear_run got=%b want=0", head_clear_run_o); end
            next_cycle();
        end
        eng_res_valid_i = 1'b1;
        res_ready_i = {CH{1'b1}};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (res_valid_o !== onehot(k + 1)) begin bad++; $display("FAIL drain res_valid got=%b want=%b", res_valid_o, onehot(k + 1)); end
            total++; if (head_clear_run_o !== 1'b0) begin bad++; $display("FAIL drain clear_run while busy got=%b want=0", head_clear_run_o); end
            next_cycle();
        end
        eng_res_valid_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            data_clear_done_i = (c == 3);
            head_clear_done_i = (c == 5);
            exp_run = (c == 1);
            @(negedge clk);
            total++; if (data_clear_run_o !== exp_run) begin bad++; $display("FAIL drain clear_run cyc%0d got=%b want=%b", c, data_clear_run_o, exp_run); end
            total++; if (init_done_o !== (c >= 6)) begin bad++; $display("FAIL drain init_done cyc%0d got=%b want=%b", c, init_done_o, (c >= 6)); end
            if (c < 6) begin
                total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL drain clear cmd_ready cyc%0d got=%b want=0000", c, cmd_ready_o); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_orphan_reset();
        bring_up();
        @(negedge clk);
        total++; if (orphan_err_o !== 1'b0) begin bad++; $display("FAIL orphan initial got=%b want=0", orphan_err_o); end
        next_cycle();
        eng_res_valid_i = 1'b1;
        eng_res_i = {$urandom, $urandom};
        @(negedge clk);
        total++; if (eng_res_ready_o !== 1'b1) begin bad++; $display("FAIL orphan eng_res_ready got=%b want=1", eng_res_ready_o); end
        total++; if (res_valid_o !== 4'b0000) begin bad++; $display("FAIL orphan res_valid got=%b want=0000", res_valid_o); end
        next_cycle();
        eng_res_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (orphan_err_o !== 1'b1) begin bad++; $display("FAIL orphan sticky step%0d got=%b want=1", k, orphan_err_o); end
            next_cycle();
        end
        for (int n = 0; n < CH; n++) cmd_i[n*CW +: CW] = chan_word(n + 8);
        cmd_valid_i = {CH{1'b1}};
        eng_ready_i = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        eng_res_valid_i = 1'b1;
        res_ready_i = {CH{1'b1}};
        #1;
        rst = 1'b1;
        #1;
        total++; if (cmd_ready_o !== 4'b0000) begin bad++; $display("FAIL midreset cmd_ready got=%b want=0000", cmd_ready_o); end
        total++; if (eng_valid_o !== 1'b0) begin bad++; $display("FAIL midreset eng_valid got=%b want=0", eng_valid_o); end
        total++; if (eng_cmd_o !== 64'h0) begin bad++; $display("FAIL midreset eng_cmd got=%h want=0", eng_cmd_o); end
        total++; if (res_valid_o !== 4'b0000) begin bad++; $display("FAIL midreset res_valid got=%b want=0000", res_valid_o); end
        total++; if ({head_clear_run_o, data_clear_run_o, init_done_o, orphan_err_o} !== 4'b0000) begin
            bad++; $display("FAIL midreset run/init/orphan got=%b want=0000", {head_clear_run_o, data_clear_run_o, init_done_o, orphan_err_o});
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int q[$];
        bit m_ev;
        logic [CW-1:0] m_cmd;
        int m_rr;
        int g;
        int c;
        bit allow;
        bit pop;
        logic [CH-1:0] exp_ready;
        logic [CH-1:0] exp_res;
        bring_up();
        m_ev = 1'b0;
        m_cmd = {CW{1'b0}};
        m_rr = 0;
        for (int n = 0; n < 400; n++) begin
            cmd_valid_i = CH'($urandom);
            for (int k = 0; k < CH; k++) cmd_i[k*CW +: CW] = {$urandom, $urandom};
            eng_ready_i = ($urandom_range(2) != 0);
            res_ready_i = CH'($urandom);
            eng_res_valid_i = (q.size() > 0) && ($urandom_range(1) == 1);
            eng_res_i = {$urandom, $urandom};
            allow = (!m_ev || eng_ready_i) && (q.size() < TD);
            g = -1;
            for (int i = 0; i < CH; i++) begin
                c = (m_rr + i) % CH;
                if (allow && g < 0 && cmd_valid_i[c]) g = c;
            end
            exp_ready = (g >= 0) ? onehot(g) : {CH{1'b0}};
            exp_res = (eng_res_valid_i && q.size() > 0) ? onehot(q[0]) : {CH{1'b0}};
            @(negedge clk);
            total++; if (cmd_ready_o !== exp_ready) begin bad++; $display("FAIL rand cmd_ready n%0d got=%b want=%b", n, cmd_ready_o, exp_ready); end
            total++; if (eng_valid_o !== m_ev) begin bad++; $display("FAIL rand eng_valid n%0d got=%b want=%b", n, eng_valid_o, m_ev); end
            if (m_ev) begin
                total++; if (eng_cmd_o !== m_cmd) begin bad++; $display("FAIL rand eng_cmd n%0d got=%h want=%h", n, eng_cmd_o, m_cmd); end
            end
            total++; if (res_valid_o !== exp_res) begin bad++; $display("FAIL rand res_valid n%0d got=%b want=%b", n, res_valid_o, exp_res); end
            if (q.size() > 0) begin
                total++; if (eng_res_ready_o !== res_ready_i[q[0]]) begin bad++; $display("FAIL rand eng_res_ready n%0d got=%b want=%b", n, eng_res_ready_o, res_ready_i[q[0]]); end
            end
            total++; if (res_o !== eng_res_i) begin bad++; $display("FAIL rand res_o n%0d got=%h want=%h", n, res_o, eng_res_i); end
            pop = eng_res_valid_i && (q.size() > 0) && res_ready_i[q[0]];
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(g);
                m_ev = 1'b1;
                m_cmd = cmd_i[g*CW +: CW];
                m_rr = (g + 1) % CH;
            end else if (eng_ready_i) begin
                m_ev = 1'b0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_init();
        test_rr();
        test_full();
        test_inorder();
        test_drain();
        test_orphan_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
